// File: rtl/bpt_pkg.sv
// Shared types and counter helpers for the branch pattern table.
// The update entry index width follows the default table size (256 entries).
package bpt_pkg;

  localparam int unsigned BPT_IDX_LEN = 8;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  typedef struct packed {
    logic [BPT_IDX_LEN-1:0] idx;
    logic                   taken;
  } upd_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == 2'b11) ? c : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == 2'b00) ? c : ctr_t'(c - 2'd1);
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    return taken ? sat_inc(c) : sat_dec(c);
  endfunction

endpackage

// File: rtl/bpt_update_fifo.sv
// Resolved-branch update queue; head is visible combinationally, no push-to-pop bypass.
module bpt_update_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WIDTH   = 9,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned OCC_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready_c,
  output logic             head_valid_c,
  output logic [WIDTH-1:0] head_data_c,
  input  logic             pop,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic             push_fire;
  logic             pop_fire;

  // Ready comes from registered occupancy, so a full queue takes no push even when popping.
  assign ready_c      = rst && (occupancy < OCC_W'(DEPTH));
  assign head_valid_c = (occupancy != '0);
  assign head_data_c  = mem_q[head_q];
  assign push_fire    = push && ready_c;
  assign pop_fire     = pop && head_valid_c;

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[tail_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      occupancy <= '0;
    end else begin
      if (push_fire) tail_q <= PTR_W'(tail_q + PTR_W'(1));
      if (pop_fire)  head_q <= PTR_W'(head_q + PTR_W'(1));
      case ({push_fire, pop_fire})
        2'b10:   occupancy <= OCC_W'(occupancy + OCC_W'(1));
        2'b01:   occupancy <= OCC_W'(occupancy - OCC_W'(1));
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/branch_pattern_table.sv
// Local-history pattern table: hashed 2-bit counter lookup plus queued counter updates.
// Define BPT_BYPASS_EN to forward a same-cycle counter write to a colliding lookup.
module branch_pattern_table
  import bpt_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 256,
  parameter int unsigned HISTORY_LEN = 8,
  parameter int unsigned PC_BITS     = 8,
  parameter int unsigned UPD_DEPTH   = 4,
  localparam int unsigned IDX_LEN    = $clog2(NUM_ENTRIES),
  localparam int unsigned OCC_W      = $clog2(UPD_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IN_predValid,
  input  logic [HISTORY_LEN-1:0] IN_predHist,
  input  logic [PC_BITS-1:0]     IN_predPc,
  output logic                   OUT_predValid,
  output logic                   OUT_predTaken,
  output logic [IDX_LEN-1:0]     OUT_predIdx,
  input  logic                   IN_updValid,
  input  logic [IDX_LEN-1:0]     IN_updIdx,
  input  logic                   IN_updTaken,
  output logic                   OUT_updReady,
  output logic [OCC_W-1:0]       OUT_updPending
);

  localparam int unsigned ENTRY_W = $bits(upd_entry_t);

  ctr_t               ctr_q [NUM_ENTRIES];
  logic [IDX_LEN-1:0] pred_idx_c;
  ctr_t               pred_ctr_c;
  upd_entry_t         push_entry_c;
  upd_entry_t         head_entry_c;
  logic [ENTRY_W-1:0] head_data_c;
  logic               drain_c;
  logic [IDX_LEN-1:0] drain_idx_c;
  ctr_t               drain_ctr_c;

  bpt_update_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (IN_updValid),
    .push_data    (push_entry_c),
    .ready_c      (OUT_updReady),
    .head_valid_c (drain_c),
    .head_data_c  (head_data_c),
    .pop          (drain_c),
    .occupancy    (OUT_updPending)
  );

  always_comb begin
    push_entry_c       = '0;
    push_entry_c.idx   = BPT_IDX_LEN'(IN_updIdx);
    push_entry_c.taken = IN_updTaken;
  end

  // Drain side: one read-modify-write per cycle from the queue head.
  assign head_entry_c = upd_entry_t'(head_data_c);
  assign drain_idx_c  = IDX_LEN'(head_entry_c.idx);
  assign drain_ctr_c  = ctr_next(ctr_q[drain_idx_c], head_entry_c.taken);

  assign pred_idx_c = IDX_LEN'(IN_predHist) ^ IDX_LEN'(IN_predPc);

`ifdef BPT_BYPASS_EN
  assign pred_ctr_c = (drain_c && (drain_idx_c == pred_idx_c)) ? drain_ctr_c
                                                               : ctr_q[pred_idx_c];
`else
  assign pred_ctr_c = ctr_q[pred_idx_c];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (drain_c) begin
      ctr_q[drain_idx_c] <= drain_ctr_c;
    end
  end

  // Prediction result; taken/idx hold while no lookup is requested.
  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_predValid <= 1'b0;
      OUT_predTaken <= 1'b0;
      OUT_predIdx   <= '0;
    end else begin
      OUT_predValid <= IN_predValid;
      if (IN_predValid) begin
        OUT_predTaken <= pred_ctr_c[1];
        OUT_predIdx   <= pred_idx_c;
      end
    end
  end

endmodule
